// File: rtl/tx_queue_pkg.sv
// tx_queue_pkg: types and constants shared by tx_queue and byte_fifo.
//   state_t     - sequencer states
//   UART_BYTE_W - width of one byte on the uart_tx path
package tx_queue_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACT  = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular byte buffer, depth 2**ADDR_W, with registered level/full/empty.
// The caller decides what a rejected write means; this core simply ignores a push
// while full and a pop while empty.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               synchronous clear of pointers and level (wins over push/pop)
//   push_i, wr_data_i     enqueue strobe and byte
//   pop_i, rd_data_o      dequeue strobe and current head byte
//   full_o, empty_o       occupancy flags after the current edge
//   level_o               occupancy, ADDR_W+1 bits
module byte_fifo
  import tx_queue_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [UART_BYTE_W-1:0] wr_data_i,
  input  logic                   pop_i,
  output logic [UART_BYTE_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        level_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LVL_FULL);
      empty_q  <= (level_d == '0);
    end
  end

  // Storage needs no reset; the head is only read once level says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/tx_queue.sv
// tx_queue: byte FIFO plus start/active/done sequencer in front of uart_tx.
// Handlers push bytes at clock rate; the sequencer hands them to uart_tx one at a time.
// Optional build macro TX_QUEUE_CHECKSUM_EN adds csum_req: after a request, once the
// queue drains, an XOR of all bytes popped since reset/flush/last checksum is sent.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   wr_data, wr_en, flush         enqueue byte/strobe, synchronous queue clear
//   csum_req (macro only)         request a checksum byte after the queue drains
//   full, empty, level, idle      queue status; idle = drained and sequencer idle
//   overflow, tx_lost             sticky: dropped write / uart_tx never went active
//   tx_data, tx_start             byte and one-cycle start pulse to uart_tx
//   tx_active, tx_done            uart_tx busy level and end-of-byte pulse
//
// state       | meaning
// S_IDLE      | waiting for a byte (or pending checksum) and uart_tx not busy
// S_WAIT_ACT  | start issued, waiting for tx_active; timeout marks the byte lost
// S_WAIT_DONE | uart_tx busy, waiting for tx_done
// S_GAP       | one-cycle spacer before the next start
module tx_queue
  import tx_queue_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int ACTIVE_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_en,
  input  logic                   flush,
`ifdef TX_QUEUE_CHECKSUM_EN
  input  logic                   csum_req,
`endif
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   idle,
  output logic                   overflow,
  output logic                   tx_lost,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_active,
  input  logic                   tx_done
);

  localparam int CNT_W = $clog2(ACTIVE_TIMEOUT + 1);
  // Loaded on the start edge and checked for zero in S_WAIT_ACT, so the byte is
  // declared lost exactly ACTIVE_TIMEOUT cycles after tx_start rises.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACTIVE_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q;
  logic                   overflow_q, overflow_d;
  logic                   tx_lost_q, tx_lost_d;

  logic                   fifo_full, fifo_empty;
  logic [UART_BYTE_W-1:0] fifo_head;
  logic                   pop, send_csum, launch, lost_set;

`ifdef TX_QUEUE_CHECKSUM_EN
  logic [UART_BYTE_W-1:0] csum_q, csum_d;
  logic                   csum_pend_q, csum_pend_d;
`endif

  // A write while full is rejected even if a pop frees a slot on the same edge.
  byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .flush_i   (flush),
    .push_i    (wr_en && !fifo_full),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_WAIT_ACT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT_ACT: begin
        if (tx_active)       state_d = S_WAIT_DONE;
        else if (tx_done)    state_d = S_GAP;
        else if (cnt_q == '0) state_d = S_GAP;
        else                 cnt_d = cnt_q - 1'b1;
      end
      S_WAIT_DONE: begin
        if (tx_done) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: queued bytes take precedence over a pending checksum.
  always_comb begin
    pop       = 1'b0;
    send_csum = 1'b0;
    lost_set  = 1'b0;
    if (state_q == S_IDLE && !tx_active) begin
      if (!fifo_empty) pop = 1'b1;
`ifdef TX_QUEUE_CHECKSUM_EN
      else if (csum_pend_q) send_csum = 1'b1;
`endif
    end
    if (state_q == S_WAIT_ACT && !tx_active && !tx_done && cnt_q == '0) lost_set = 1'b1;
  end

  assign launch = pop || send_csum;

  always_comb begin
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;
    tx_lost_d  = tx_lost_q;
    if (launch) begin
`ifdef TX_QUEUE_CHECKSUM_EN
      tx_data_d = send_csum ? csum_q : fifo_head;
`else
      tx_data_d = fifo_head;
`endif
    end
    if (flush) begin
      overflow_d = 1'b0;
      tx_lost_d  = 1'b0;
    end else begin
      if (wr_en && fifo_full) overflow_d = 1'b1;
      if (lost_set)           tx_lost_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
      tx_lost_q  <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_start_q <= launch;
      overflow_q <= overflow_d;
      tx_lost_q  <= tx_lost_d;
    end
  end

`ifdef TX_QUEUE_CHECKSUM_EN
  always_comb begin
    csum_d      = csum_q;
    csum_pend_d = csum_pend_q || csum_req;
    if (flush) begin
      csum_d      = '0;
      csum_pend_d = 1'b0;
    end else if (send_csum) begin
      csum_d      = '0;
      csum_pend_d = csum_req;
    end else if (pop) begin
      csum_d = csum_q ^ fifo_head;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q      <= '0;
      csum_pend_q <= 1'b0;
    end else begin
      csum_q      <= csum_d;
      csum_pend_q <= csum_pend_d;
    end
  end

  assign idle = fifo_empty && (state_q == S_IDLE) && !csum_pend_q;
`else
  assign idle = fifo_empty && (state_q == S_IDLE);
`endif

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_q;
  assign tx_lost  = tx_lost_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule
